// File: rtl/adder_stream_driver_if.sv
// Host and adder-side signals of the adder stream driver, bundled as one interface.
// The master modport belongs to the driver; the slave modport belongs to the host and adder side.
interface adder_stream_driver_if #(
    parameter int W = 16
) ();
    // Handshake: the host raises start for one sampled cycle while the driver is idle.
    // The driver raises irdy for exactly one cycle, with op0 on din, and then streams op1 and op2.
    // The adder answers with ordy and sum_in.
    // done pulses once per accepted start and carries result and the error flags.
    logic         start;
    logic [W-1:0] op0;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err_mismatch;
    logic         err_timeout;
    logic         irdy;
    logic [W-1:0] din;
    logic         ordy;
    logic [W-1:0] sum_in;
    logic [2:0]   dbg_state;

    modport master (
        input  start, op0, op1, op2, ordy, sum_in,
        output busy, done, result, err_mismatch, err_timeout, irdy, din, dbg_state
    );

    modport slave (
        output start, op0, op1, op2, ordy, sum_in,
        input  busy, done, result, err_mismatch, err_timeout, irdy, din, dbg_state
    );
endinterface

// File: rtl/adder_stream_driver.sv
// Streams three operands into the adder and waits for the sum, with a bounded wait.
// It checks the returned sum against a local modulo-2^W sum.
module adder_stream_driver #(
    parameter int W       = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    adder_stream_driver_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEND0 = 3'd1;
    localparam logic [2:0] SEND1 = 3'd2;
    localparam logic [2:0] SEND2 = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  op1_q, op1_d, op2_q, op2_d, expect_q, expect_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          irdy_q, irdy_d, busy_q, busy_d, done_q, done_d;
    logic [W-1:0]  din_q, din_d, result_q, result_d;
    logic          mm_q, mm_d, to_q, to_d;

    // Outputs are registered, so each state's bus values are prepared on the edge that enters it.
    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        expect_d = expect_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        mm_d     = mm_q;
        to_d     = to_q;
        irdy_d   = 1'b0;
        din_d    = '0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op1_d    = bus.op1;
                    op2_d    = bus.op2;
                    expect_d = bus.op0 + bus.op1 + bus.op2;
                    mm_d     = 1'b0;
                    to_d     = 1'b0;
                    irdy_d   = 1'b1;
                    din_d    = bus.op0;
                    state_d  = SEND0;
                end
            end
            SEND0: begin
                din_d   = op1_q;
                state_d = SEND1;
            end
            SEND1: begin
                din_d   = op2_q;
                state_d = SEND2;
            end
            SEND2: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A response in the last allowed cycle still counts as success.
                if (bus.ordy) begin
                    result_d = bus.sum_in;
                    mm_d     = (bus.sum_in != expect_q);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == LAST) begin
                    result_d = '0;
                    to_d     = 1'b1;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            expect_q <= '0;
            cnt_q    <= '0;
            irdy_q   <= 1'b0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            mm_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            expect_q <= expect_d;
            cnt_q    <= cnt_d;
            irdy_q   <= irdy_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            mm_q     <= mm_d;
            to_q     <= to_d;
        end
    end

    assign bus.irdy         = irdy_q;
    assign bus.din          = din_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.err_mismatch = mm_q;
    assign bus.err_timeout  = to_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_adder_stream_driver.sv
// Directed bench for adder_stream_driver.
// The bench plays both the host and the adder, and every expected value is hand-computed.
module tb_adder_stream_driver;
    localparam int W       = 16;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    adder_stream_driver_if #(.W(W)) bus ();

    adder_stream_driver #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting in IDLE.
    // ordy_at is the WAIT-cycle index at which the adder answers; -1 means it never answers.
    // noise re-pulses start while busy and leaves a stale ordy high during the send phase.
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] ret, input logic [W-1:0] exp_res, input int ordy_at,
                          input logic exp_mm, input logic exp_to, input bit noise);
        bus.op0   = a;
        bus.op1   = b;
        bus.op2   = c;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.op0   = ~a;
        bus.op1   = ~b;
        bus.op2   = ~c;
        if (noise) begin
            bus.ordy   = 1'b1;
            bus.sum_in = ~ret;
        end
        chk("send0_irdy", 32'(bus.irdy), 32'd1);
        chk("send0_din", 32'(bus.din), 32'(a));
        chk("send0_busy", 32'(bus.busy), 32'd1);
        chk("send0_mm_clr", 32'(bus.err_mismatch), 32'd0);
        chk("send0_to_clr", 32'(bus.err_timeout), 32'd0);
        tick;
        chk("send1_irdy", 32'(bus.irdy), 32'd0);
        chk("send1_din", 32'(bus.din), 32'(b));
        if (noise) bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("send2_irdy", 32'(bus.irdy), 32'd0);
        chk("send2_din", 32'(bus.din), 32'(c));
        tick;
        bus.ordy = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("wait_irdy", 32'(bus.irdy), 32'd0);
            chk("wait_din", 32'(bus.din), 32'd0);
            chk("wait_done", 32'(bus.done), 32'd0);
            if (noise && k == 0) bus.start = 1'b1;
            bus.ordy   = (k == ordy_at);
            bus.sum_in = ret;
            tick;
            bus.start = 1'b0;
            bus.ordy  = 1'b0;
            if (k == ordy_at) break;
        end
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_result", 32'(bus.result), 32'(exp_res));
        chk("done_mm", 32'(bus.err_mismatch), 32'(exp_mm));
        chk("done_to", 32'(bus.err_timeout), 32'(exp_to));
        tick;
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_result_held", 32'(bus.result), 32'(exp_res));
        chk("idle_mm_held", 32'(bus.err_mismatch), 32'(exp_mm));
        chk("idle_to_held", 32'(bus.err_timeout), 32'(exp_to));
    endtask

    initial begin
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.op0    = '0;
        bus.op1    = '0;
        bus.op2    = '0;
        bus.ordy   = 1'b0;
        bus.sum_in = '0;
        #2 reset = 1'b1;
        #2;
        chk("rst_irdy", 32'(bus.irdy), 32'd0);
        chk("rst_din", 32'(bus.din), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_mm", 32'(bus.err_mismatch), 32'd0);
        chk("rst_to", 32'(bus.err_timeout), 32'd0);
        tick;
        tick;
        reset = 1'b0;
        tick;

        // basic
        do_txn(16'd1, 16'd2, 16'd3, 16'h0006, 16'h0006, 0, 1'b0, 1'b0, 1'b0);
        // carries out of W bits are discarded
        do_txn(16'hFFFF, 16'hFFFF, 16'h0003, 16'h0001, 16'h0001, 0, 1'b0, 1'b0, 1'b0);
        // adder returns a wrong sum
        do_txn(16'd10, 16'd20, 16'd30, 16'h003B, 16'h003B, 0, 1'b1, 1'b0, 1'b0);
        // next accepted start clears the mismatch flag; response after 3 WAIT cycles
        do_txn(16'd100, 16'd200, 16'd300, 16'h0258, 16'h0258, 2, 1'b0, 1'b0, 1'b0);
        // no response at all
        do_txn(16'd7, 16'd8, 16'd9, 16'h0018, 16'h0000, -1, 1'b0, 1'b1, 1'b0);
        // response in the last allowed WAIT cycle
        do_txn(16'd1, 16'd1, 16'd1, 16'h0003, 16'h0003, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
        // start while busy and a stale ordy during the send phase
        do_txn(16'h1234, 16'h1111, 16'h0001, 16'h2346, 16'h2346, 1, 1'b0, 1'b0, 1'b1);

        // asynchronous reset in the middle of SEND1
        bus.op0   = 16'd50;
        bus.op1   = 16'd60;
        bus.op2   = 16'd70;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        chk("pre_rst_din", 32'(bus.din), 32'd60);
        #2 reset = 1'b1;
        #1;
        chk("midrst_irdy", 32'(bus.irdy), 32'd0);
        chk("midrst_din", 32'(bus.din), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        tick;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("postrst_done", 32'(bus.done), 32'd0);
            chk("postrst_busy", 32'(bus.busy), 32'd0);
        end
        do_txn(16'd4, 16'd5, 16'd6, 16'd15, 16'd15, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
